// File: rtl/serial_addsub_fa.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_fa
// Brief    : Bit-serial adder/subtractor, one decoder-style full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_fa #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic             cin_msb;
  logic [CNT_W-1:0] bit_cnt;

  logic [7:0]       minterm;
  logic             fa_s;
  logic             fa_co;

  // Full-adder cell: one-hot minterm decode, outputs as OR of minterms.
  assign minterm = 8'd1 << {a_sr[0], b_sr[0], carry};
  assign fa_s    = minterm[1] | minterm[2] | minterm[4] | minterm[7];
  assign fa_co   = minterm[3] | minterm[5] | minterm[6] | minterm[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // All WIDTH bits are in the work register once the counter reaches WIDTH.
        if (bit_cnt == LAST_CNT) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          step = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      work     <= '0;
      carry    <= 1'b0;
      cin_msb  <= 1'b0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= 1'b0;
      if (load) begin
        a_sr    <= a;
        b_sr    <= b ^ {WIDTH{sub}};
        work    <= '0;
        carry   <= sub;
        cin_msb <= 1'b0;
        bit_cnt <= '0;
      end
      if (step) begin
        work    <= {fa_s, work[WIDTH-1:1]};
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        cin_msb <= carry;
        carry   <= fa_co;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (finish) begin
        sum      <= work;
        cout     <= carry;
        overflow <= cin_msb ^ carry;
        done     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_fa.sv
`default_nettype none
// Bench for serial_addsub_fa: cycle-level reference model for WIDTH=8 plus
// directed vectors, and an exhaustive sweep of a WIDTH=3 instance.
module tb_serial_addsub_fa;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, cout, overflow;
  logic [7:0] sum;

  logic       start3 = 1'b0;
  logic       sub3 = 1'b0;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;
  logic       busy3, done3, cout3, overflow3;
  logic [2:0] sum3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub_fa #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  serial_addsub_fa #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .overflow(overflow3)
  );

  // Arithmetic reference: {overflow, cout, sum} for a w-bit add or subtract.
  function automatic logic [9:0] ref_op(input int w, input int av, input int bv, input bit sb);
    int m, raw, sa, sbv, r;
    logic [7:0] s;
    logic c, o;
    m   = 1 << w;
    raw = sb ? av + (m - 1 - bv) + 1 : av + bv;
    s   = 8'(raw % m);
    c   = (raw >= m);
    sa  = (av >= m / 2) ? av - m : av;
    sbv = (bv >= m / 2) ? bv - m : bv;
    r   = sb ? sa - sbv : sa + sbv;
    o   = (r < -(m / 2)) || (r >= m / 2);
    return {o, c, s};
  endfunction

  // Timing model: done WIDTH+1 edges after accept, idle again one edge later.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_sum = '0;
  logic       m_cout = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_cnt = 0;
  int         m_a = 0;
  int         m_b = 0;
  bit         m_sub = 1'b0;
  logic [9:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1; m_cnt = 0; m_a = int'(a); m_b = int'(b); m_sub = sub;
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 9) begin
        m_res  = ref_op(8, m_a, m_b, m_sub);
        m_sum  = m_res[7:0];
        m_cout = m_res[8];
        m_ovf  = m_res[9];
        m_done = 1'b1;
      end else if (m_cnt == 10) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // One WIDTH=8 operation with a single-cycle start pulse and literal result checks.
  task automatic op8(input string name, input logic [7:0] av, input logic [7:0] bv, input logic sb,
                     input logic [7:0] es, input logic ec, input logic eo);
    int cyc, busy_cnt, done_at;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; sub = sb;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_cnt = 0; done_at = -1;
    while (busy && cyc < 30) begin
      busy_cnt++;
      if (done) done_at = cyc;
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_at"}, 32'(done_at), 32'd9);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd10);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    check({name, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    int n, ndone, done_at;
    logic [7:0] first_sum, second_sum;
    logic [9:0] r;

    #3 rst_n = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_flags", 32'({cout, overflow}), 32'd0);
    check("reset3_busy", 32'(busy3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fork
      forever begin
        @(negedge clk);
        check("cmp_busy", 32'(busy), 32'(m_busy));
        check("cmp_done", 32'(done), 32'(m_done));
        check("cmp_sum", 32'(sum), 32'(m_sum));
        check("cmp_cout", 32'(cout), 32'(m_cout));
        check("cmp_ovf", 32'(overflow), 32'(m_ovf));
      end
    join_none

    op8("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Start held high; operands change while busy.
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03; sub = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h11; sub = 1'b1;
    @(negedge clk);
    sub = 1'b0;
    n = 0; ndone = 0; first_sum = '0; second_sum = '0;
    while (ndone < 2 && n < 40) begin
      if (done) begin
        if (ndone == 0) first_sum = sum; else second_sum = sum;
        ndone++;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("hold_start_ops", 32'(ndone), 32'd2);
    check("hold_start_first", 32'(first_sum), 32'h08);
    check("hold_start_second", 32'(second_sum), 32'hBB);
    wait_idle();

    op8("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    op8("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Exhaustive WIDTH=3 sweep.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          start3 = 1'b1; a3 = 3'(i); b3 = 3'(j); sub3 = s[0];
          @(negedge clk);
          start3 = 1'b0;
          n = 0; done_at = -1;
          while (busy3 && n < 15) begin
            if (done3) done_at = n;
            @(negedge clk);
            n++;
          end
          r = ref_op(3, i, j, s[0]);
          check("w3_done_at", 32'(done_at), 32'd4);
          check("w3_sum", 32'(sum3), 32'(r[2:0]));
          check("w3_cout", 32'(cout3), 32'(r[8]));
          check("w3_ovf", 32'(overflow3), 32'(r[9]));
        end
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
